pulse_period_monitor: RTL

Receive-side checker for the periodic single-cycle pulse produced by the team's interval/delay generator. Measures the spacing between successive pulses and declares lock after a configurable number of on-time intervals. Flags early and late/missing pulses and keeps a saturating fault count. Sits next to any consumer of the delay pulse, as a health monitor and for bring-up.

---
 rtl/pulse_mon_pkg.sv | 19 +
 rtl/period_timer.sv | 39 +++
 rtl/pulse_period_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pulse_mon_pkg.sv
// Shared definitions for the delay-pulse generator and its period monitor.
// Defaults live here so both sides agree on the pulse spacing.
package pulse_mon_pkg;

    // Generator runs N=12500, i.e. N+1 clocks between pulses.
    localparam int PERIOD_DEF   = 12501;
    localparam int CBITS_DEF    = 14;
    localparam int TOL_DEF      = 0;
    localparam int LOCK_CNT_DEF = 2;
    localparam int FAULT_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } mon_state_t;

endpackage

// File: rtl/period_timer.sv
// Free-running interval counter, cleared by each pulse, plus the
// acceptance-window compare against the expected period.
module period_timer #(
    parameter int PERIOD = 12501,
    parameter int CBITS  = 14,
    parameter int TOL    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CBITS-1:0] phase,
    output logic             good,
    output logic             early,
    output logic             timeout
);

    localparam logic [CBITS-1:0] WIN_LO = CBITS'(PERIOD - 1 - TOL);
    localparam logic [CBITS-1:0] WIN_HI = CBITS'(PERIOD - 1 + TOL);
    localparam logic [CBITS-1:0] PH_MAX = '1;

    // Phase restarts after each pulse, otherwise counts up and parks at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase <= '0;
        else if (sig_in)
            phase <= '0;
        else if (phase != PH_MAX)
            phase <= phase + CBITS'(1);
    end

    // Classify the current cycle; the window is inclusive on both ends,
    // so a pulse on the timeout cycle is still good
    always_comb begin
        good    = sig_in && (phase >= WIN_LO) && (phase <= WIN_HI);
        early   = sig_in && (phase <  WIN_LO);
        timeout = !sig_in && (phase == WIN_HI);
    end

endmodule

// File: rtl/pulse_period_monitor.sv
// Health monitor for the periodic delay pulse: acquires lock after
// LOCK_CNT on-time intervals, flags early and late/missing pulses and
// keeps a saturating fault count.
module pulse_period_monitor
    import pulse_mon_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,
    parameter int CBITS    = CBITS_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_in,
    input  logic               clr,
    output logic               locked,
    output logic               early,
    output logic               late,
    output logic [FAULT_W-1:0] fault_cnt,
    output logic [CBITS-1:0]   phase
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);

    mon_state_t  state, state_nxt;
    logic [GW-1:0] good_cnt, good_cnt_nxt;
    logic        win_good, win_early, win_timeout;
    logic        early_nxt, late_nxt, fault_evt;

    period_timer #(
        .PERIOD (PERIOD),
        .CBITS  (CBITS),
        .TOL    (TOL)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .phase   (phase),
        .good    (win_good),
        .early   (win_early),
        .timeout (win_timeout)
    );

    // State, good-interval count and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
            early    <= 1'b0;
            late     <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            locked   <= (state_nxt == LOCKED);
            early    <= early_nxt;
            late     <= late_nxt;
        end
    end

    // Next-state logic; IDLE and FAULT only wait for a reference pulse
    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        early_nxt    = 1'b0;
        late_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (sig_in) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            ACQUIRE: begin
                if (win_good) begin
                    if (good_cnt == LOCK_LAST) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + GW'(1);
                    end
                end else if (win_early) begin
                    // Early pulse restarts acquisition from itself
                    early_nxt    = 1'b1;
                    good_cnt_nxt = '0;
                end else if (win_timeout) begin
                    late_nxt  = 1'b1;
                    state_nxt = FAULT;
                end
            end
            LOCKED: begin
                if (win_early) begin
                    early_nxt = 1'b1;
                    state_nxt = FAULT;
                end else if (win_timeout) begin
                    late_nxt  = 1'b1;
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (sig_in) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = IDLE;
                good_cnt_nxt = '0;
            end
        endcase
    end

    assign fault_evt = early_nxt | late_nxt;

    // Saturating fault counter; a clear coinciding with an event leaves 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_cnt <= '0;
        else if (clr)
            fault_cnt <= FAULT_W'(fault_evt);
        else if (fault_evt && (fault_cnt != '1))
            fault_cnt <= fault_cnt + FAULT_W'(1);
    end

endmodule
